// File: rtl/ripple_count_monitor_if.sv
// Bundle between the ripple counter monitor and its downstream consumer.
// The monitor drives status; the consumer side supplies raw q_in and clr.
interface ripple_count_monitor_if #(
  parameter int WIDTH      = 3,
  parameter int WRAP_CNT_W = 8
);
  logic [WIDTH-1:0]      q_in;
  logic                  clr;
  logic [WIDTH-1:0]      count_out;
  logic                  valid;
  logic                  step_pulse;
  logic                  wrap_pulse;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic                  err_pulse;
  logic                  step_err;

  modport slave (
    input  q_in, clr,
    output count_out, valid, step_pulse, wrap_pulse,
    output wrap_count, err_pulse, step_err
  );

  modport master (
    output q_in, clr,
    input  count_out, valid, step_pulse, wrap_pulse,
    input  wrap_count, err_pulse, step_err
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronises and deglitches an async ripple down counter, then checks
// every accepted value for a legal single down-step and counts wraps.
module ripple_count_monitor #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_CNT_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  ripple_count_monitor_if.slave mon
);
  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  localparam logic [3:0] SC = 4'(STABLE_CYCLES);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WRAP_CNT_W-1:0] WC_MAX = '1;
  localparam logic [WRAP_CNT_W-1:0] WC_ONE = WRAP_CNT_W'(1);

  logic [0:0]            state;
  logic [WIDTH-1:0]      s1;
  logic [WIDTH-1:0]      s2;
  logic [WIDTH-1:0]      cand;
  logic [3:0]            stab;
  logic [3:0]            stab_nxt;
  logic [1:0]            warm;
  logic                  acc;

  logic [WIDTH-1:0]      count_q;
  logic                  valid_q;
  logic                  step_q;
  logic                  wrap_q;
  logic                  errp_q;
  logic [WRAP_CNT_W-1:0] wc_q;
  logic [WRAP_CNT_W-1:0] wc_base;
  logic [WRAP_CNT_W-1:0] wc_nxt;
  logic                  step_err_q;
  logic                  err_nxt;

  logic [WIDTH-1:0]      dec;
  logic                  moved;
  logic                  ev_step;
  logic                  ev_wrap;
  logic                  ev_err;

  // Accept exactly once, on the edge the run length reaches the threshold.
  always_comb begin
    stab_nxt = stab;
    acc      = 1'b0;
    if (warm == 2'd0) begin
      if (s2 != cand) begin
        stab_nxt = 4'd1;
      end else if (stab != SC) begin
        stab_nxt = stab + 4'd1;
      end
      acc = (stab_nxt == SC) &&
            ((stab != SC) || (s2 != cand));
    end
  end

  assign dec     = count_q - ONE;
  assign moved   = acc && (state == TRACK) &&
                   (s2 != count_q);
  assign ev_step = moved && (s2 == dec);
  assign ev_wrap = ev_step && (count_q == '0);
  assign ev_err  = moved && (s2 != dec);

  // clr lands first so a same-cycle event still counts.
  always_comb begin
    wc_base = mon.clr ? '0 : wc_q;
    wc_nxt  = wc_base;
    if (ev_wrap && (wc_base != WC_MAX)) begin
      wc_nxt = wc_base + WC_ONE;
    end
    err_nxt = (step_err_q & ~mon.clr) | ev_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      s1         <= '0;
      s2         <= '0;
      cand       <= '0;
      stab       <= '0;
      warm       <= 2'd2;
      count_q    <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      errp_q     <= 1'b0;
      wc_q       <= '0;
      step_err_q <= 1'b0;
    end else begin
      s1 <= mon.q_in;
      s2 <= s1;
      if (warm != 2'd0) begin
        warm <= warm - 2'd1;
      end else begin
        cand <= s2;
        stab <= stab_nxt;
      end
      step_q     <= ev_step;
      wrap_q     <= ev_wrap;
      errp_q     <= ev_err;
      wc_q       <= wc_nxt;
      step_err_q <= err_nxt;
      if (acc) begin
        count_q <= s2;
        if (state == INIT) begin
          valid_q <= 1'b1;
          state   <= TRACK;
        end
      end
    end
  end

  assign mon.count_out  = count_q;
  assign mon.valid      = valid_q;
  assign mon.step_pulse = step_q;
  assign mon.wrap_pulse = wrap_q;
  assign mon.wrap_count = wc_q;
  assign mon.err_pulse  = errp_q;
  assign mon.step_err   = step_err_q;
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor: vector table plus
// hand sequences for latency, glitch, clr-on-wrap and mid-run reset.
module tb_ripple_count_monitor;
  typedef struct {
    logic [2:0] q;
    logic       clr;
    int         cyc;
    bit         chk;
    logic [2:0] cnt;
    logic       err;
    int         wc;
    int         steps;
    int         wraps;
    int         errs;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] q   = 3'd0;
  logic       clr = 1'b0;

  int total  = 0;
  int bad    = 0;
  int n_step = 0;
  int n_wrap = 0;
  int n_err  = 0;
  int both   = 0;
  int seen7  = 0;
  int row_id = 0;
  bit watch7 = 1'b0;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  ripple_count_monitor_if #(.WIDTH(3), .WRAP_CNT_W(8)) ia ();
  ripple_count_monitor_if #(.WIDTH(3), .WRAP_CNT_W(2)) ib ();

  assign ia.q_in = q;
  assign ib.q_in = q;
  assign ia.clr  = clr;
  assign ib.clr  = clr;

  ripple_count_monitor #(
    .WIDTH(3), .STABLE_CYCLES(2), .WRAP_CNT_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .mon(ia)
  );

  ripple_count_monitor #(
    .WIDTH(3), .STABLE_CYCLES(2), .WRAP_CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .mon(ib)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (ia.step_pulse) n_step++;
    if (ia.wrap_pulse) n_wrap++;
    if (ia.err_pulse) n_err++;
    if (ia.step_pulse && ia.err_pulse) both++;
    if (watch7 && ia.count_out == 3'd7) seen7++;
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0d exp=%0d",
               name, row_id, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] q_v, input logic clr_v,
    input int cyc_v, input bit chk_v,
    input logic [2:0] cnt_v, input logic err_v,
    input int wc_v, input int st_v,
    input int wr_v, input int er_v);
    vec_t v;
    v.q = q_v; v.clr = clr_v; v.cyc = cyc_v;
    v.chk = chk_v; v.cnt = cnt_v; v.err = err_v;
    v.wc = wc_v; v.steps = st_v;
    v.wraps = wr_v; v.errs = er_v;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    q = v.q;
    clr = v.clr;
    n_step = 0;
    n_wrap = 0;
    n_err = 0;
    repeat (v.cyc) @(posedge clk);
    #1;
    if (v.chk) begin
      chk("count", 32'(ia.count_out), 32'(v.cnt));
      chk("valid", 32'(ia.valid), 32'd1);
      chk("step_err", 32'(ia.step_err), 32'(v.err));
      chk("wrap_count", 32'(ia.wrap_count), v.wc);
      chk("n_step", n_step, v.steps);
      chk("n_wrap", n_wrap, v.wraps);
      chk("n_err", n_err, v.errs);
      row_id++;
    end
  endtask

  initial begin
    for (int v = 6; v >= 0; v--)
      tbl_a.push_back(mk(3'(v), 0, 6, 1,
                         3'(v), 0, 0, 1, 0, 0));
    tbl_a.push_back(mk(7, 0, 6, 1, 7, 0, 1, 1, 1, 0));
    tbl_a.push_back(mk(6, 0, 6, 1, 6, 0, 1, 1, 0, 0));
    tbl_a.push_back(mk(5, 0, 6, 1, 5, 0, 1, 1, 0, 0));

    for (int v = 3; v >= 0; v--)
      tbl_b.push_back(mk(3'(v), 0, 6, 1,
                         3'(v), 0, 1, 1, 0, 0));
    tbl_b.push_back(mk(7, 0, 6, 1, 7, 0, 2, 1, 1, 0));
    tbl_b.push_back(mk(6, 0, 6, 1, 6, 0, 2, 1, 0, 0));
    tbl_b.push_back(mk(5, 0, 6, 1, 5, 0, 2, 1, 0, 0));
    tbl_b.push_back(mk(2, 0, 6, 1, 2, 1, 2, 0, 0, 1));
    tbl_b.push_back(mk(1, 0, 6, 1, 1, 1, 2, 1, 0, 0));
    tbl_b.push_back(mk(1, 1, 6, 1, 1, 0, 0, 0, 0, 0));
    tbl_b.push_back(mk(1, 0, 6, 1, 1, 0, 0, 0, 0, 0));

    rst = 1'b1;
    q = 3'd7;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(ia.count_out), 0);
    chk("rst_valid", 32'(ia.valid), 0);
    chk("rst_pulses", 32'({ia.step_pulse,
        ia.wrap_pulse, ia.err_pulse}), 0);
    chk("rst_wc_err", 32'({ia.wrap_count,
        ia.step_err}), 0);

    @(negedge clk);
    rst = 1'b0;
    n_step = 0;
    n_wrap = 0;
    n_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("valid_early", 32'(ia.valid), 0);
    @(posedge clk);
    #1;
    chk("valid_edge4", 32'(ia.valid), 1);
    chk("count_edge4", 32'(ia.count_out), 7);
    repeat (2) @(posedge clk);
    #1;
    chk("init_pulses", n_step + n_wrap + n_err, 0);
    chk("init_err", 32'(ia.step_err), 0);

    foreach (tbl_a[i]) apply(tbl_a[i]);

    watch7 = 1'b1;
    apply(mk(7, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(4, 0, 6, 1, 4, 0, 1, 1, 0, 0));
    chk("never7", seen7, 0);
    watch7 = 1'b0;

    foreach (tbl_b[i]) apply(tbl_b[i]);

    apply(mk(0, 0, 6, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      apply(mk(7, 0, 6, 0, 0, 0, 0, 0, 0, 0));
      for (int v = 6; v >= 0; v--)
        apply(mk(3'(v), 0, 6, 0, 0, 0, 0, 0, 0, 0));
    end
    chk("wc_a_five", 32'(ia.wrap_count), 5);
    chk("wc_b_sat", 32'(ib.wrap_count), 3);
    chk("five_count", 32'(ia.count_out), 0);
    chk("five_err", 32'(ia.step_err), 0);

    @(negedge clk);
    q = 3'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clrwrap_pulse", 32'(ia.wrap_pulse), 1);
    chk("clrwrap_wc_a", 32'(ia.wrap_count), 1);
    chk("clrwrap_wc_b", 32'(ib.wrap_count), 1);
    @(negedge clk);
    clr = 1'b0;

    for (int v = 6; v >= 3; v--)
      apply(mk(3'(v), 0, 6, 1, 3'(v), 0, 1, 1, 0, 0));

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_count", 32'(ia.count_out), 0);
    chk("mid_rst_valid", 32'(ia.valid), 0);
    chk("mid_rst_wc", 32'(ia.wrap_count), 0);
    chk("mid_rst_other", 32'({ia.step_pulse,
        ia.wrap_pulse, ia.err_pulse, ia.step_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    n_step = 0;
    n_wrap = 0;
    n_err = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("re_valid_early", 32'(ia.valid), 0);
    @(posedge clk);
    #1;
    chk("re_valid", 32'(ia.valid), 1);
    chk("re_count", 32'(ia.count_out), 3);
    repeat (2) @(posedge clk);
    #1;
    chk("re_pulses", n_step + n_wrap + n_err, 0);

    chk("step_err_overlap", both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous ripple down counter.
- Brings the counter's unsynchronised, glitch-prone q output into the system clock domain and deglitches it.
- Checks every accepted transition for a legal single down-step, detects underflow wrap (0 -> max), counts wraps and flags illegal jumps.
- Its outputs are clean, registered count and status for downstream control logic.

Parameters:
- WIDTH, 3: width of the monitored counter value.
- STABLE_CYCLES, 2: consecutive identical synchronised samples required before a value is accepted (legal range 1..15).
- WRAP_CNT_W, 8: width of the saturating wrap counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- q_in  input  WIDTH  raw ripple counter output, asynchronous to clk.
- clr  input  1  synchronous clear of wrap_count and step_err; does not affect tracking.
- count_out  output  WIDTH  last accepted (deglitched) counter value.
- valid  output  1  high once the first value has been accepted after reset.
- step_pulse  output  1  one-cycle pulse on each accepted legal down-step.
- wrap_pulse  output  1  one-cycle pulse on each accepted step 0 -> 2^WIDTH-1.
- wrap_count  output  WRAP_CNT_W  number of wraps since reset or clr; saturates at all ones.
- err_pulse  output  1  one-cycle pulse on each accepted illegal transition.
- step_err  output  1  sticky error flag; set by err_pulse, cleared by rst or clr.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values:
  - All outputs 0; state INIT.
  - Synchroniser flops s1, s2 = 0; candidate = 0; stable counter = 0.
  - Warm-up counter = 2.
- Synchroniser: two-flop chain q_in -> s1 -> s2.
- Warm-up: for the 2 edges after rst deasserts, the filter ignores s2 and holds candidate and stable counter at 0.
- Filter, per edge after warm-up:
  - If s2 != candidate: candidate <= s2, stab <= 1.
  - Else: stab <= min(stab+1, STABLE_CYCLES).
  - A value is accepted at the edge where stab becomes STABLE_CYCLES (this includes the load edge when STABLE_CYCLES = 1).
  - Acceptance fires once per stable run.
- Latency: count_out updates 2+STABLE_CYCLES edges after q_in settles (4 edges by default). Pulse outputs are registered and coincident with the count_out update.
- A glitch shorter than STABLE_CYCLES synchronised samples is never accepted.
- State INIT:
  - First acceptance: count_out <= value, valid <= 1, go to TRACK.
  - No step, wrap or err pulse is generated.
- State TRACK, acceptance of value v with v != count_out:
  - v == count_out-1 mod 2^WIDTH: step_pulse = 1.
  - Additionally, if count_out == 0: wrap_pulse = 1 and wrap_count increments, saturating.
  - Any other v (up-step or multi-step jump): err_pulse = 1, step_err <= 1, count_out <= v (resynchronise); no step_pulse and no wrap_pulse.
  - Acceptance of v == count_out produces no pulse and no change.
- clr:
  - Clears wrap_count and step_err.
  - A wrap or error event in the same cycle is applied after the clear: wrap_count = 1, step_err = 1.
- rst mid-operation: returns to the full reset state; valid drops to 0 on the reset edge.
- Pulses are exactly one cycle wide; step_pulse and err_pulse are never high in the same cycle.

Test Plan:
- rst for 2 cycles, then q_in = 7 held -> valid = 1 and count_out = 7 at edge 4 after warm-up; no pulses; step_err = 0.
- q_in walks 7,6,...,0,7, each value held 6 cycles -> 8 step_pulses, exactly one wrap_pulse (at 0 -> 7), wrap_count = 1, step_err = 0.
- Held 5, then a 1-cycle 7 glitch, then 4 held -> count_out goes 5 -> 4 with one step_pulse; count_out is never 7; no err_pulse.
- 5 -> 2 jump, then 2 -> 1 -> err_pulse and step_err = 1 with count_out = 2, then step_pulse with count_out = 1; step_err stays 1 until clr = 1 clears it.
- WRAP_CNT_W = 2, five full down cycles -> wrap_count saturates at 3; clr asserted on a wrap cycle -> wrap_count = 1.
- rst asserted mid-walk at count_out = 3 -> next edge: all outputs 0, valid = 0; then q_in = 3 -> re-accepted in INIT with no pulses.
